line_rasteriser: RTL and testbench

LINE_RASTERISER -- requirements
Module: line_rasteriser

---
 rtl/line_rasteriser.sv | 176 +++++++++++++++++
 tb/tb_line_rasteriser.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_rasteriser.sv
// line_rasteriser
//   Bresenham line rasteriser. A start request latches two endpoints and a
//   colour. The line is then emitted one pixel per transfer on a
//   valid/ready pixel stream, and done pulses once after the endpoint pixel.
//
//   Ports
//     clk, rst              clock, synchronous active-high reset
//     start                 draw request, accepted only while ready=1
//     x0, y0, x1, y1        endpoints, sampled when start is accepted
//     colour_in             line colour, sampled with the endpoints
//     abort                 cancel the line in progress
//     ready / busy          idle / line in progress
//     pix_x, pix_y          current pixel coordinates
//     pix_colour            current pixel colour
//     pix_valid, pix_ready  pixel stream handshake (transfer when both high)
//     pix_last              endpoint pixel marker
//     done                  one-cycle pulse after the last pixel transfers
module line_rasteriser #(
   parameter int unsigned COORD_W  = 9,
   parameter int unsigned COLOUR_W = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [COORD_W-1:0]  x0,
   input  logic [COORD_W-1:0]  y0,
   input  logic [COORD_W-1:0]  x1,
   input  logic [COORD_W-1:0]  y1,
   input  logic [COLOUR_W-1:0] colour_in,
   input  logic                abort,
   output logic                ready,
   output logic                busy,
   output logic [COORD_W-1:0]  pix_x,
   output logic [COORD_W-1:0]  pix_y,
   output logic [COLOUR_W-1:0] pix_colour,
   output logic                pix_valid,
   input  logic                pix_ready,
   output logic                pix_last,
   output logic                done
);

   localparam int unsigned EW = COORD_W + 2;
   localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_e;

   state_e state_q, state_d;

   logic [COORD_W-1:0]  x0_q, y0_q, x1_q, y1_q, x0_d, y0_d, x1_d, y1_d;
   logic [COORD_W-1:0]  cur_x_q, cur_y_q, cur_x_d, cur_y_d;
   logic [COLOUR_W-1:0] colour_q, colour_d;
   logic signed [EW-1:0] dx_q, dy_q, err_q, dx_d, dy_d, err_d;
   logic                sx_neg_q, sy_neg_q, sx_neg_d, sy_neg_d;

   logic [COORD_W-1:0]  adx, ady;
   logic signed [EW:0]  e2, dx_ext, dy_ext;
   logic signed [EW-1:0] dx_add, dy_add;
   logic                at_end, step_x, step_y;

   assign adx    = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
   assign ady    = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
   assign at_end = (cur_x_q == x1_q) && (cur_y_q == y1_q);

   // e2 = 2*err needs one extra bit; dx/dy are sign-extended to match so
   // both comparisons are done signed at full width.
   assign e2     = {err_q, 1'b0};
   assign dx_ext = {dx_q[EW-1], dx_q};
   assign dy_ext = {dy_q[EW-1], dy_q};
   assign step_x = (e2 >= dy_ext);
   assign step_y = (e2 <= dx_ext);
   assign dy_add = step_x ? dy_q : '0;
   assign dx_add = step_y ? dx_q : '0;

   assign ready      = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign pix_valid  = (state_q == S_DRAW);
   assign pix_last   = pix_valid && at_end;
   assign done       = (state_q == S_DONE) && !abort;
   assign pix_x      = cur_x_q;
   assign pix_y      = cur_y_q;
   assign pix_colour = colour_q;

   always_comb begin
      state_d  = state_q;
      x0_d     = x0_q;
      y0_d     = y0_q;
      x1_d     = x1_q;
      y1_d     = y1_q;
      colour_d = colour_q;
      cur_x_d  = cur_x_q;
      cur_y_d  = cur_y_q;
      dx_d     = dx_q;
      dy_d     = dy_q;
      err_d    = err_q;
      sx_neg_d = sx_neg_q;
      sy_neg_d = sy_neg_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_SETUP;
               x0_d     = x0;
               y0_d     = y0;
               x1_d     = x1;
               y1_d     = y1;
               colour_d = colour_in;
            end
         end
         S_SETUP: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               state_d  = S_DRAW;
               dx_d     = $signed({2'b00, adx});
               dy_d     = -$signed({2'b00, ady});
               err_d    = dx_d + dy_d;
               sx_neg_d = (x1_q < x0_q);
               sy_neg_d = (y1_q < y0_q);
               cur_x_d  = x0_q;
               cur_y_d  = y0_q;
            end
         end
         S_DRAW: begin
            // abort wins over a transfer in the same cycle
            if (abort) begin
               state_d = S_IDLE;
            end else if (pix_ready) begin
               if (at_end) begin
                  state_d = S_DONE;
               end else begin
                  if (step_x) cur_x_d = sx_neg_q ? (cur_x_q - ONE) : (cur_x_q + ONE);
                  if (step_y) cur_y_d = sy_neg_q ? (cur_y_q - ONE) : (cur_y_q + ONE);
                  err_d = err_q + dy_add + dx_add;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x0_q     <= '0;
         y0_q     <= '0;
         x1_q     <= '0;
         y1_q     <= '0;
         colour_q <= '0;
         cur_x_q  <= '0;
         cur_y_q  <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         err_q    <= '0;
         sx_neg_q <= 1'b0;
         sy_neg_q <= 1'b0;
      end else begin
         x0_q     <= x0_d;
         y0_q     <= y0_d;
         x1_q     <= x1_d;
         y1_q     <= y1_d;
         colour_q <= colour_d;
         cur_x_q  <= cur_x_d;
         cur_y_q  <= cur_y_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         err_q    <= err_d;
         sx_neg_q <= sx_neg_d;
         sy_neg_q <= sy_neg_d;
      end
   end

endmodule

// File: tb/tb_line_rasteriser.sv
// tb_line_rasteriser
//   Scoreboard bench for line_rasteriser. The driver pushes the expected
//   pixel list of each line (from a plain integer line model or a constant
//   table) and the expected pixel count. A negedge monitor pops and compares
//   every transferred pixel, checks that done follows the last pixel, and
//   checks that outputs are held while the consumer stalls.
module tb_line_rasteriser;
   localparam int CW = 9;
   localparam int LW = 3;

   logic          clk = 1'b0;
   logic          rst, start, abort, pix_ready;
   logic [CW-1:0] x0, y0, x1, y1;
   logic [LW-1:0] colour_in;
   logic          ready, busy, pix_valid, pix_last, done;
   logic [CW-1:0] pix_x, pix_y;
   logic [LW-1:0] pix_colour;

   always #5 clk = ~clk;

   line_rasteriser #(.COORD_W(CW), .COLOUR_W(LW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1), .colour_in(colour_in),
      .abort(abort), .ready(ready), .busy(busy),
      .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_last(pix_last), .done(done)
   );

   typedef struct {int x; int y; int c; bit last;} pix_t;
   pix_t exp_q[$];
   int   cnt_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   ready_mode = 0;   // 0: always ready, 1: toggle, 2: random

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Line model: the error-term stepping rule on plain integers.
   function automatic void model(input int ax0, input int ay0, input int ax1,
                                 input int ay1, input int col);
      int dx, dy, sx, sy, err, e2, x, y, n;
      dx  = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
      dy  = (ay1 >= ay0) ? ay0 - ay1 : ay1 - ay0;
      sx  = (ax1 >= ax0) ? 1 : -1;
      sy  = (ay1 >= ay0) ? 1 : -1;
      err = dx + dy;
      x = ax0; y = ay0; n = 0;
      forever begin
         pix_t p;
         p.x = x; p.y = y; p.c = col; p.last = (x == ax1) && (y == ay1);
         exp_q.push_back(p);
         n++;
         if (p.last) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; x += sx; end
         if (e2 <= dx) begin err += dx; y += sy; end
      end
      cnt_q.push_back(((dx > -dy) ? dx : -dy) + 1);
   endfunction

   // Consumer backpressure
   initial begin
      pix_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = ~pix_ready;
            default: pix_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor / scoreboard
   logic          last_prev = 1'b0;
   logic          hold_prev = 1'b0;
   logic [CW-1:0] hx, hy;
   logic [LW-1:0] hc;
   logic          hl;
   int            npix = 0;

   always @(negedge clk) begin
      if (rst) begin
         last_prev = 1'b0; hold_prev = 1'b0; npix = 0;
         exp_q.delete(); cnt_q.delete();
      end else begin
         check("done_after_last", done, last_prev);
         if (hold_prev) begin
            check("hold_valid", pix_valid, 1);
            check("hold_x", pix_x, hx);
            check("hold_y", pix_y, hy);
            check("hold_colour", pix_colour, hc);
            check("hold_last", pix_last, hl);
         end
         if (done) begin
            if (cnt_q.size() == 0) check("unexpected_done", done, 0);
            else                   check("pixel_count", npix, cnt_q.pop_front());
            check("pixels_left_at_done", exp_q.size(), 0);
            npix = 0;
         end
         last_prev = 1'b0;
         if (pix_valid && pix_ready && !abort) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pixel", pix_valid, 0);
            end else begin
               pix_t e;
               e = exp_q.pop_front();
               check("pix_x", pix_x, e.x);
               check("pix_y", pix_y, e.y);
               check("pix_colour", pix_colour, e.c);
               check("pix_last", pix_last, e.last);
            end
            npix++;
            last_prev = pix_last;
         end
         hold_prev = pix_valid && !pix_ready && !abort;
         hx = pix_x; hy = pix_y; hc = pix_colour; hl = pix_last;
         // an abort while busy drops the rest of the line at the next edge
         if (abort && busy) begin
            exp_q.delete(); cnt_q.delete(); npix = 0;
            last_prev = 1'b0; hold_prev = 1'b0;
         end
      end
   end

   task automatic wait_ready(input int budget);
      for (int i = 0; i < budget && !ready; i++) begin
         @(posedge clk); #1;
      end
      check("ready_timeout", ready, 1);
   endtask

   // Issue one line; returns #1 after the first DRAW edge.
   task automatic draw(input int ax0, input int ay0, input int ax1, input int ay1,
                       input int col, input bit use_model);
      wait_ready(3000);
      if (use_model) model(ax0, ay0, ax1, ay1, col);
      x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
      colour_in = LW'(col);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("setup_busy", busy, 1);
      check("setup_not_ready", ready, 0);
      check("setup_no_valid", pix_valid, 0);
      @(posedge clk); #1;
      check("first_valid_latency", pix_valid, 1);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int oct[8][2];
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      x0 = '0; y0 = '0; x1 = '0; y1 = '0; colour_in = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", ready, 1);
      check("rst_busy", busy, 0);
      check("rst_valid", pix_valid, 0);
      check("rst_last", pix_last, 0);
      check("rst_done", done, 0);
      check("rst_x", pix_x, 0);
      check("rst_y", pix_y, 0);
      check("rst_colour", pix_colour, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // (0,0)->(5,2), constant expectation table
      begin
         int tx[6] = '{0, 1, 2, 3, 4, 5};
         int ty[6] = '{0, 0, 1, 1, 2, 2};
         for (int i = 0; i < 6; i++) begin
            pix_t p;
            p.x = tx[i]; p.y = ty[i]; p.c = 5; p.last = (i == 5);
            exp_q.push_back(p);
         end
         cnt_q.push_back(6);
      end
      ready_mode = 0;
      draw(0, 0, 5, 2, 5, 1'b0);

      // toggling backpressure, x decreasing, steep
      ready_mode = 1;
      draw(10, 10, 7, 16, 3, 1'b1);

      // degenerate single pixel
      ready_mode = 0;
      draw(100, 50, 100, 50, 6, 1'b1);

      // long line, full-width error terms
      draw(0, 0, 319, 239, 1, 1'b1);
      draw(511, 511, 0, 0, 2, 1'b1);
      draw(0, 511, 511, 0, 7, 1'b1);

      // all octants around a centre plus axis and diagonal cases
      oct = '{'{230, 210}, '{210, 230}, '{190, 230}, '{170, 210},
              '{170, 190}, '{190, 170}, '{210, 170}, '{230, 190}};
      ready_mode = 2;
      for (int i = 0; i < 8; i++) draw(200, 200, oct[i][0], oct[i][1], i, 1'b1);
      draw(5, 5, 40, 5, 1, 1'b1);
      draw(40, 5, 5, 5, 2, 1'b1);
      draw(7, 3, 7, 30, 3, 1'b1);
      draw(7, 30, 7, 3, 4, 1'b1);
      draw(10, 10, 30, 30, 5, 1'b1);
      draw(30, 30, 10, 10, 6, 1'b1);

      // abort on the 3rd pixel, then a short vertical line
      ready_mode = 0;
      draw(0, 0, 8, 0, 4, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort_third_pixel_x", pix_x, 2);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_ready", ready, 1);
      check("abort_no_done", done, 0);
      check("abort_no_valid", pix_valid, 0);
      @(posedge clk); #1;
      check("abort_no_done_later", done, 0);
      draw(1, 1, 1, 3, 2, 1'b1);

      // reset pulse mid-line with start held high
      draw(0, 0, 40, 30, 3, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1; start = 1'b1;
      x0 = 9'd50; y0 = 9'd50; x1 = 9'd60; y1 = 9'd60; colour_in = 3'd7;
      @(posedge clk); #1;
      check("midrst_ready", ready, 1);
      check("midrst_busy", busy, 0);
      check("midrst_valid", pix_valid, 0);
      check("midrst_last", pix_last, 0);
      check("midrst_done", done, 0);
      check("midrst_x", pix_x, 0);
      check("midrst_y", pix_y, 0);
      check("midrst_colour", pix_colour, 0);
      rst = 1'b0;
      model(3, 4, 9, 1, 1);
      x0 = 9'd3; y0 = 9'd4; x1 = 9'd9; y1 = 9'd1; colour_in = 3'd1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_after_rst_accepted", busy, 1);

      // random lines under random backpressure
      ready_mode = 2;
      for (int i = 0; i < 14; i++) begin
         draw($urandom_range(0, 511), $urandom_range(0, 511),
              $urandom_range(0, 511), $urandom_range(0, 511),
              $urandom_range(0, 7), 1'b1);
      end

      wait_ready(3000);
      repeat (3) @(posedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      check("counts_drained", cnt_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
